dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts load/store requests from the pipeline's MEM stage through a valid/ready handshake.
- Inserts a programmable number of wait states, performs the word access on an internal RAM, and returns one response per request.
- Drives a stall back to the pipeline registers while an access is outstanding, so the CPU can stop treating data memory as single-cycle combinational.

Parameters:
- ADDR_W, 8: word-address width; RAM holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states between accept and response, range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request (MEM_MemWr or load in flight).
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (MEM_Result).
- req_wdata  in  32  store data (MEM_BusB).
- req_ready  out  1  responder accepts request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access, valid with rsp_valid.
- stall  out  1  hold PC, IF/ID and ID/EXE; freeze EXE/MEM.

Behaviour:
- Reset (Reset=0, async) outputs: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1. Accept when req_valid=1.
  - On accept, latch wr/addr/wdata and set cnt=WAIT_CYCLES-1.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - When cnt==0, go to RESP.
  - Request inputs are ignored (latched copy used).
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0. Next state is always IDLE.
  - This produces one bubble cycle between back-to-back requests.
- Latency: accept at edge T, so rsp_valid is high during cycle T+WAIT_CYCLES+1.
- Access execution: on the transition into RESP.
  - Store: RAM[word] <= wdata. This is the commit point.
  - Load: rsp_rdata <= RAM[word], registered.
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap subtraction).
  - word = off[ADDR_W+1:2].
  - err = (addr[1:0]!=0) | (off[31:ADDR_W+2]!=0).
- Error access: no RAM write; rsp_rdata=0; rsp_err=1 with rsp_valid.
- stall is combinational: (state==IDLE & req_valid) | (state==WAIT). It is 0 in RESP, so the pipeline advances in the same cycle the data is returned.
- Reset mid-operation: an outstanding request is dropped and no response is issued. A store still in WAIT is not committed.
- WAIT_CYCLES=0: response in cycle T+1; stall is high only during the accept cycle.
- Counter wrap: not possible; the counter is only loaded in IDLE and saturates at 0.
- Read-after-write to the same word across consecutive requests returns the new data (the write committed before the next accept).

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), WAIT_W=4 constant, response-data-on-error constant (32'h0).
- One natural sub-module, dmem_ram:
  - single-port synchronous RAM, 2^ADDR_W x 32.
  - ports: clock, we, addr, din, registered dout.
- The FSM, counter, decode and stall logic stay in dmem_responder.

Test Plan:
- Reset with req_valid=1 held → all outputs at reset values. After release, accept occurs on the first edge; rsp_valid is seen 3 cycles later with WAIT_CYCLES=2.
- Store addr 0x10, data 0xDEADBEEF, then load 0x10 → load response rsp_rdata=0xDEADBEEF, rsp_err=0. stall is high 3 cycles per access; there is 1 bubble between the accesses.
- Load addr 0x12 (misaligned) → rsp_err=1, rsp_rdata=0. Load addr 0x400 with ADDR_W=8 → rsp_err=1, RAM unchanged.
- WAIT_CYCLES=0, store then load 0x3FC, data 0x12345678 → each rsp_valid at T+1; load returns 0x12345678.
- Store 0x20=0xAAAA5555 accepted, Reset pulsed low during WAIT → no rsp_valid, state=IDLE. A later load of 0x20 returns the prior contents, not 0xAAAA5555.
- req_valid held high continuously for 4 requests → exactly 4 rsp_valid pulses, spaced WAIT_CYCLES+2 cycles apart. req_ready=0 outside IDLE.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared types and constants for the MEM-stage data-memory
//               responder: FSM state encoding, wait-counter width and the
//               value returned on the read-data bus for stores and errors.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    // Responder FSM states, encoding fixed so it can be probed consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of the wait-state counter (WAIT_CYCLES range 0..15).
    localparam int WAIT_W = 4;

    // Read data presented for stores, error accesses and when idle.
    localparam logic [31:0] c_err_rdata = 32'h0000_0000;

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous RAM, 2^ADDR_W x 32, with a
//               registered read port (read-before-write on the same address).
//               Contents are never reset.
// Ports       : clk  - rising-edge clock
//               we   - write enable
//               addr - word address
//               din  - write data
//               dout - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_dout;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_dout <= r_mem[addr];
    end

    assign dout = r_dout;

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Responder end of the MEM-stage data-memory interface.
//               Accepts one load/store per valid/ready handshake, waits
//               WAIT_CYCLES cycles, performs the word access on the internal
//               RAM and returns a one-cycle response. Stall is raised while
//               an access is outstanding.
// Ports       : CLK       - rising-edge clock
//               Reset     - asynchronous active-low reset
//               req_valid - request present
//               req_wr    - 1 = store, 0 = load
//               req_addr  - byte address
//               req_wdata - store data
//               req_ready - request accepted this cycle
//               rsp_valid - one-cycle response strobe
//               rsp_rdata - load data (0 for stores/errors)
//               rsp_err   - misaligned or out-of-range access
//               stall     - pipeline hold while access outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    // Counter load value on accept; irrelevant when there are no wait states.
    localparam logic [WAIT_W-1:0] c_cnt_init =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;
    logic              r_wr;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;

    logic              w_accept;
    logic              w_sel_wr;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [31:0]       w_off;
    logic [ADDR_W-1:0] w_word;
    logic              w_err;
    logic              w_enter_resp;
    logic              w_ram_we;
    logic [31:0]       w_ram_dout;
    logic              w_unused;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // In IDLE the live request is decoded so that a zero-wait access can
    // commit on its accept edge; afterwards the latched copy is used.
    assign w_sel_wr    = (r_state == ST_IDLE) ? req_wr    : r_wr;
    assign w_sel_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_sel_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_off  = w_sel_addr - BASE_ADDR;
    assign w_word = w_off[ADDR_W+1:2];
    assign w_err  = (w_sel_addr[1:0] != 2'b00) || (w_off[31:ADDR_W+2] != '0);

    // Byte-lane bits of the offset carry no information for word accesses.
    assign w_unused = ^w_off[1:0];

    // RESP is never followed by RESP, so this marks the access edge.
    // Gated by Reset so nothing commits while reset is held.
    assign w_enter_resp = (w_state_nxt == ST_RESP) && Reset;
    assign w_ram_we     = w_enter_resp && w_sel_wr && !w_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_cnt_nxt   = c_cnt_init;
                    w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (CLK),
        .we   (w_ram_we),
        .addr (w_word),
        .din  (w_sel_wdata),
        .dout (w_ram_dout)
    );

    // In RESP the selected address is the latched one, so w_err is the
    // decode of the access being answered.
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) && w_err;
    assign rsp_rdata = ((r_state == ST_RESP) && !r_wr && !w_err) ? w_ram_dout
                                                                  : c_err_rdata;
    // Qualified by Reset so the pipeline is not held during reset.
    assign stall     = Reset && (((r_state == ST_IDLE) && req_valid) ||
                                 (r_state == ST_WAIT));

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder. Two instances: index 0
//               with WAIT_CYCLES=2, index 1 with WAIT_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [1:0]  stall;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (2),
        .BASE_ADDR   (32'h0000_0000)
    ) u_dut_w2 (
        .CLK       (clk),
        .Reset     (rst_n[0]),
        .req_valid (req_valid[0]),
        .req_wr    (req_wr[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_ready (req_ready[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0]),
        .stall     (stall[0])
    );

    dmem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (0),
        .BASE_ADDR   (32'h0000_0000)
    ) u_dut_w0 (
        .CLK       (clk),
        .Reset     (rst_n[1]),
        .req_valid (req_valid[1]),
        .req_wr    (req_wr[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_ready (req_ready[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1]),
        .stall     (stall[1])
    );

    typedef struct {
        int          sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // One complete request; nowait=1 means inputs are already driven and the
    // next rising edge is the accept edge.
    task automatic do_req(input int s, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag, input bit nowait);
        int lat;
        if (!nowait) @(negedge clk);
        req_valid[s] = 1'b1;
        req_wr[s]    = wr;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        #1;
        check({tag, " ready_at_req"}, 32'(req_ready[s]), 32'd1);
        check({tag, " stall_at_req"}, 32'(stall[s]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        lat = 0;
        while (!rsp_valid[s] && lat < 40) begin
            check({tag, " stall_wait"}, 32'(stall[s]), 32'd1);
            check({tag, " ready_wait"}, 32'(req_ready[s]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(wait_of(s)));
        if (rsp_valid[s]) begin
            check({tag, " rdata"}, rsp_rdata[s], exp_rdata);
            check({tag, " err"}, 32'(rsp_err[s]), 32'(exp_err));
            check({tag, " stall_resp"}, 32'(stall[s]), 32'd0);
            check({tag, " ready_resp"}, 32'(req_ready[s]), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, " valid_after"}, 32'(rsp_valid[s]), 32'd0);
        check({tag, " ready_after"}, 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        int pulses;
        int ready_err;
        int pulse_err;

        vecs.push_back('{0, 1'b0, 32'h10,  32'h0,         32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h12,  32'h0,         32'h0,        1'b1});
        vecs.push_back('{0, 1'b1, 32'h0,   32'h5A5A5A5A,  32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 32'h400, 32'h11111111,  32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 32'h400, 32'h0,         32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 32'h0,   32'h0,         32'h5A5A5A5A, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h14,  32'hCAFEF00D,  32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h10,  32'h0,         32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h14,  32'h0,         32'hCAFEF00D, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h3FC, 32'h0BADC0DE,  32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h3FC, 32'h0,         32'h0BADC0DE, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h20,  32'h01020304,  32'h0,        1'b0});
        vecs.push_back('{1, 1'b1, 32'h3FC, 32'h12345678,  32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 32'h3FC, 32'h0,         32'h12345678, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h3FD, 32'h0,         32'h0,        1'b1});
        vecs.push_back('{1, 1'b1, 32'h401, 32'hFFFFFFFF,  32'h0,        1'b1});

        // Reset with a store request held on both instances.
        rst_n     = 2'b00;
        req_valid = 2'b11;
        req_wr    = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = 32'h10;
            req_wdata[i] = 32'hDEADBEEF;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst ready",  32'(req_ready[i]), 32'd1);
            check("rst valid",  32'(rsp_valid[i]), 32'd0);
            check("rst rdata",  rsp_rdata[i],      32'd0);
            check("rst err",    32'(rsp_err[i]),   32'd0);
            check("rst stall",  32'(stall[i]),     32'd0);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst_n = 2'b11;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "rst_store", 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i), 1'b0);
        end

        // Reset pulsed while a store sits in WAIT: dropped, not committed.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hAAAA5555;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("midrst stall_wait", 32'(stall[0]), 32'd1);
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        check("midrst valid", 32'(rsp_valid[0]), 32'd0);
        check("midrst ready", 32'(req_ready[0]), 32'd1);
        check("midrst stall", 32'(stall[0]),     32'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0]) pulses++;
        end
        check("midrst no_rsp", 32'(pulses), 32'd0);
        do_req(0, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0, "midrst_load", 1'b0);

        // Four back-to-back loads with req_valid held high.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b0;
        req_addr[0]  = 32'h14;
        pulses    = 0;
        ready_err = 0;
        pulse_err = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (req_ready[0] !== ((k % 4 == 0) || (k > 15))) ready_err++;
            if (rsp_valid[0] !== ((k % 4 == 3) && (k <= 15))) pulse_err++;
            if (rsp_valid[0]) begin
                pulses++;
                check("b2b rdata", rsp_rdata[0], 32'hCAFEF00D);
                if (pulses == 4) req_valid[0] = 1'b0;
            end
        end
        check("b2b pulses",    32'(pulses),    32'd4);
        check("b2b spacing",   32'(pulse_err), 32'd0);
        check("b2b ready",     32'(ready_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
